romulus_round_scheduler: RTL and testbench
==========================================

ROMULUS_ROUND_SCHEDULER -- requirements
Module: romulus_round_scheduler

Interface
REQ-001 SHALL have parameter ROUNDS, default 40, meaning total TBC rounds per block.
REQ-002 SHALL have parameter RNDS_PER_CLK, default 4, meaning unrolled rounds executed per RUN cycle.
REQ-003 SHALL have parameter CNTW, default 6, meaning width of one round constant.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request to encrypt one block.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-008 SHALL have port ready  output  1  high when start is accepted (state IDLE).
REQ-009 SHALL have port load  output  1  datapath state/tweakey load strobe.
REQ-010 SHALL have port sen  output  1  state register round enable.
REQ-011 SHALL have port zen  output  1  tweakey schedule enable.
REQ-012 SHALL have port constant  output  CNTW*RNDS_PER_CLK  packed round constants; earliest round in LSBs.
REQ-013 SHALL have port last_rnd  output  1  high on final RUN cycle.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL require ROUNDS to be an exact multiple of RNDS_PER_CLK; N = ROUNDS/RNDS_PER_CLK RUN cycles per block.
REQ-016 SHALL implement states IDLE, LOAD, RUN, DONE, held in registers.
REQ-017 SHALL move IDLE->LOAD when start=1 and abort=0 at a clock edge; start outside IDLE is ignored.
REQ-018 SHALL stay in LOAD exactly one cycle with load=1, sen=0, zen=0, then enter RUN.
REQ-019 SHALL stay in RUN exactly N cycles with sen=1, zen=1; a round counter of ceil(log2(N)) bits counts 0..N-1.
REQ-020 SHALL assert last_rnd only when in RUN with round counter = N-1, then enter DONE.
REQ-021 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; latency start-edge to done = N+2 cycles.
REQ-022 SHALL hold a CNTW-bit LFSR register rc, cleared to 0 in IDLE and LOAD.
REQ-023 SHALL define one LFSR step as rc' = {rc[CNTW-2:0], rc[5]^rc[4]^1} (SKINNY 6-bit constant).
REQ-024 SHALL present in RUN field k (k=0..RNDS_PER_CLK-1) of constant = rc stepped k+1 times from the registered rc, combinationally.
REQ-025 SHALL advance rc by RNDS_PER_CLK steps at the end of every RUN cycle.
REQ-026 SHALL drive constant = 0 outside RUN.
REQ-027 SHALL return to IDLE at the next edge when abort=1 in any state, clearing rc and round counter, with no done pulse.
REQ-028 SHALL give abort priority over start when both are high in IDLE.
REQ-029 SHALL allow start on the cycle after done (back-to-back blocks, ready=1 that cycle).
REQ-030 SHALL never assert load, sen, done simultaneously; ready=1 only in IDLE.

Reset
REQ-031 SHALL on rst=1 immediately force state IDLE, rc=0, round counter=0, independent of clk.
REQ-032 SHALL during and after reset drive ready=1, load=0, sen=0, zen=0, last_rnd=0, done=0, constant=0.
REQ-033 SHALL on reset asserted mid-RUN abandon the block; no done is produced for it.

Verification
REQ-034 SHALL verify reset: rst pulse mid-RUN -> outputs at reset values within same cycle, ready=1, no done.
REQ-035 SHALL verify default run: start one cycle -> load 1 cycle, sen=zen=1 for 10 cycles, last_rnd on 10th, done on cycle 12 after start edge.
REQ-036 SHALL verify constants: first RUN cycle constant=0x3C70C1 (fields 01,03,07,0F); second RUN cycle fields 1F,3E,3D,3B.
REQ-037 SHALL verify abort in RUN cycle 5 -> IDLE next cycle, no done, next start yields constant 0x3C70C1 again.
REQ-038 SHALL verify start held high continuously -> blocks back-to-back, done every 13 cycles, starts during LOAD/RUN/DONE ignored.
REQ-039 SHALL verify start=abort=1 in IDLE -> remains IDLE, load stays 0.

Source files
------------

// File: rtl/romulus_round_scheduler.sv
// Romulus TBC round scheduler.
// Sequences one block encryption as IDLE -> LOAD -> RUN x N -> DONE.
// It supplies the datapath strobes and the packed SKINNY 6-bit round
// constants for each unrolled group of rounds.
module romulus_round_scheduler #(
  parameter int ROUNDS       = 40,
  parameter int RNDS_PER_CLK = 4,
  parameter int CNTW         = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         ready,
  output logic                         load,
  output logic                         sen,
  output logic                         zen,
  output logic [CNTW*RNDS_PER_CLK-1:0] constant,
  output logic                         last_rnd,
  output logic                         done
);

  // Number of RUN cycles per block, and the round counter sized to cover 0..N-1.
  localparam int N     = ROUNDS / RNDS_PER_CLK;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int CONSTW = CNTW * RNDS_PER_CLK;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  // Reject configurations where the unroll factor does not divide the round count.
  if ((ROUNDS % RNDS_PER_CLK) != 0 || ROUNDS < RNDS_PER_CLK || CNTW < 2) begin : g_cfg_check
    $error("romulus_round_scheduler: ROUNDS must be a positive multiple of RNDS_PER_CLK and CNTW >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   rc_q, rc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [CNTW-1:0]   rc_walk;
  logic [CNTW-1:0]   rc_run_next;
  logic [CONSTW-1:0] run_const;

  // One step of the SKINNY round-constant LFSR: shift left, feed back msb ^ msb-1 ^ 1.
  function automatic logic [CNTW-1:0] lfsr_step(input logic [CNTW-1:0] v);
    return {v[CNTW-2:0], v[CNTW-1] ^ v[CNTW-2] ^ 1'b1};
  endfunction

  // Unrolled constant chain: field k is rc stepped k+1 times; the final step
  // is also the value rc takes for the next RUN cycle.
  always_comb begin
    // NOTE: blocking assignments here are intentional -- rc_walk is a
    // combinational temporary whose value must ripple through the loop.
    rc_walk   = rc_q;
    run_const = '0;
    for (int k = 0; k < RNDS_PER_CLK; k++) begin
      rc_walk = lfsr_step(rc_walk);
      run_const[k*CNTW +: CNTW] = rc_walk;
    end
    rc_run_next = rc_walk;
  end

  // Next-state, counter, LFSR and Moore output decode; abort overrides everything.
  always_comb begin
    // NOTE: every output and next-state variable gets a default first so that
    // no path through the case leaves one unassigned (which would infer a latch).
    state_d  = state_q;
    rc_d     = rc_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    load     = 1'b0;
    sen      = 1'b0;
    zen      = 1'b0;
    last_rnd = 1'b0;
    done     = 1'b0;
    constant = '0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        rc_d  = '0;
        cnt_d = '0;
        if (start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        load    = 1'b1;
        rc_d    = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        sen      = 1'b1;
        zen      = 1'b1;
        constant = run_const;
        rc_d     = rc_run_next;
        if (cnt_q == LAST_CNT) begin
          last_rnd = 1'b1;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        rc_d    = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        rc_d    = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort cancels from any state, also winning over start in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      rc_d    = '0;
      cnt_d   = '0;
    end
  end

  // State, round counter and LFSR registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_romulus_round_scheduler.sv
// Scoreboard bench for romulus_round_scheduler (default parameters).
// Stimulus pushes expected LOAD / RUN / DONE events; a negedge monitor pops and compares.
module tb_romulus_round_scheduler;

  localparam int ROUNDS = 40;
  localparam int RPC    = 4;
  localparam int CNTW   = 6;
  localparam int N      = ROUNDS / RPC;
  localparam int CONSTW = CNTW * RPC;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              ready;
  logic              load;
  logic              sen;
  logic              zen;
  logic [CONSTW-1:0] constant;
  logic              last_rnd;
  logic              done;

  romulus_round_scheduler #(
    .ROUNDS      (ROUNDS),
    .RNDS_PER_CLK(RPC),
    .CNTW        (CNTW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .ready   (ready),
    .load    (load),
    .sen     (sen),
    .zen     (zen),
    .constant(constant),
    .last_rnd(last_rnd),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Free-running cycle index, used to timestamp expected events.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int                cyc;
    logic [CONSTW-1:0] cst;
    logic              last;
  } run_exp_t;

  int       load_q[$];
  run_exp_t run_q[$];
  int       done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event seen at cycle %0d with nothing expected", name, cyc);
  endtask

  function automatic logic [CNTW-1:0] model_step(input logic [CNTW-1:0] v);
    return {v[CNTW-2:0], v[5] ^ v[4] ^ 1'b1};
  endfunction

  // Expected events for a block accepted at the edge that makes cyc == a.
  // The first two RUN constants are hand-derived; later ones come from the model.
  task automatic push_block(input int a, input int nrun, input bit with_done);
    logic [CNTW-1:0]   rc;
    logic [CONSTW-1:0] cst;
    run_exp_t          e;
    load_q.push_back(a);
    rc = '0;
    for (int r = 0; r < nrun; r++) begin
      for (int k = 0; k < RPC; k++) begin
        rc = model_step(rc);
        cst[k*CNTW +: CNTW] = rc;
      end
      if (r == 0) cst = 24'h3C70C1;       // fields 01,03,07,0F
      else if (r == 1) cst = 24'hEFDF9F;  // fields 1F,3E,3D,3B
      e.cyc  = a + 1 + r;
      e.cst  = cst;
      e.last = (r == N - 1);
      run_q.push_back(e);
    end
    if (with_done) done_q.push_back(a + 1 + N);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},    ready,    1);
    check({tag, "_load"},     load,     0);
    check({tag, "_sen"},      sen,      0);
    check({tag, "_zen"},      zen,      0);
    check({tag, "_last_rnd"}, last_rnd, 0);
    check({tag, "_done"},     done,     0);
    check({tag, "_constant"}, constant, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_load_q_left"}, load_q.size(), 0);
    check({tag, "_run_q_left"},  run_q.size(),  0);
    check({tag, "_done_q_left"}, done_q.size(), 0);
    load_q.delete();
    run_q.delete();
    done_q.delete();
  endtask

  // One start pulse, full block, then confirm ready returns the cycle after done.
  task automatic run_block(input string tag);
    int a;
    a = cyc + 1;
    push_block(a, N, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 1) @(negedge clk);
    check({tag, "_ready_at_done"}, ready, 0);
    @(negedge clk);
    check({tag, "_ready_after_done"}, ready, 1);
    repeat (3) @(negedge clk);
    check_drained(tag);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event, and checks
  // per-cycle output relations.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("zen_follows_sen", zen, sen);
      check("load_sen_done_exclusive", ($countones({load, sen, done}) > 1), 0);
      check("ready_only_when_idle", ready, !(load || sen || done));
      if (!sen) begin
        check("constant_zero_outside_run", constant, 0);
        check("last_rnd_outside_run", last_rnd, 0);
      end
      if (load) begin
        if (load_q.size() == 0) flag_unexpected("load");
        else check("load_cycle", cyc, load_q.pop_front());
      end
      if (sen) begin
        if (run_q.size() == 0) flag_unexpected("run");
        else begin
          run_exp_t e;
          e = run_q.pop_front();
          check("run_cycle", cyc, e.cyc);
          check("run_constant", constant, e.cst);
          check("run_last_rnd", last_rnd, e.last);
        end
      end
      if (done) begin
        if (done_q.size() == 0) flag_unexpected("done");
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    int a;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;

    // Reset values while reset is held and after release.
    #1;
    check_idle_outputs("reset_hold");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Default single block: latency, constants, last_rnd.
    run_block("default_run");

    // Abort during the 5th RUN cycle, then a fresh block restarts constants.
    a = cyc + 1;
    push_block(a, 5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_sen", sen, 0);
    repeat (15) @(negedge clk);
    check_drained("abort_run");
    run_block("after_abort");

    // start held high: three back-to-back blocks 13 cycles apart.
    a = cyc + 1;
    for (int b = 0; b < 3; b++) push_block(a + 13 * b, N, 1'b1);
    start = 1'b1;
    repeat (39) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_drained("start_held");

    // start and abort together in IDLE: stays idle.
    start = 1'b1;
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("start_abort_ready", ready, 1);
      check("start_abort_load", load, 0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_drained("start_abort");

    // Asynchronous reset mid-RUN: outputs drop within the same cycle, no done.
    a = cyc + 1;
    push_block(a, 3, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_drained("reset_mid_run");
    run_block("after_reset_mid_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
